multicycle_controller: RTL and testbench

Multicycle control unit for the RV32I core, replacing the purely combinational Main_Decoder/Alu_Decoder pair when the datapath shares one ALU and one memory port across several cycles per instruction. A Moore-style state machine sequences fetch, decode, execute, memory and writeback. It adds LUI/AUIPC/JALR, all six branch conditions, a memory ready handshake, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register (IR) and the multicycle datapath muxes and enables.

---
 rtl/multicycle_controller.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: a Moore FSM sequencing fetch, decode, execute, memory and
// writeback over a shared ALU and memory port, with illegal-opcode trap and retire counter.
module multicycle_controller #(
    parameter bit          MEM_HANDSHAKE   = 1'b1,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       Opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             AdrSrc,
    output logic [1:0]       AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic [1:0]       ResultSrc,
    output logic [2:0]       ImmSrc,
    output logic [3:0]       Alu_Control,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic [3:0] {
        StFetch    = 4'd0,  StDecode  = 4'd1,  StMemAdr  = 4'd2,  StMemRead = 4'd3,
        StMemWb    = 4'd4,  StMemWrite = 4'd5, StExecR   = 4'd6,  StExecI   = 4'd7,
        StAluWb    = 4'd8,  StBranch  = 4'd9,  StJal     = 4'd10, StJalrAdr = 4'd11,
        StUpper    = 4'd12, StTrap    = 4'd13
    } state_t;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluSlt  = 4'b0100;
    localparam logic [3:0] AluSltu = 4'b0110;

    state_t     state_q, state_d, dec_state;
    logic       dec_legal, retire, set_illegal, mem_done, br_taken;
    logic [3:0] alu_exec, alu_br;

    assign mem_done = mem_ready || !MEM_HANDSHAKE;
    assign state    = state_q;

    always_comb begin
        dec_legal = 1'b1;
        dec_state = StFetch;
        case (Opcode)
            7'b0000011, 7'b0100011: dec_state = StMemAdr;
            7'b0110011:             dec_state = StExecR;
            7'b0010011:             dec_state = StExecI;
            7'b1100011:             dec_state = StBranch;
            7'b1101111:             dec_state = StJal;
            7'b1100111:             dec_state = StJalrAdr;
            7'b0110111, 7'b0010111: dec_state = StUpper;
            default: begin
                dec_legal = 1'b0;
                dec_state = TRAP_ON_ILLEGAL ? StTrap : StFetch;
            end
        endcase
    end

    // SUB only for R-type add/sub; SRA vs SRL for either form.
    always_comb begin
        alu_exec = {funct3, 1'b0};
        if (funct3 == 3'b101) begin
            alu_exec[0] = funct7_5;
        end else if (funct3 == 3'b000) begin
            alu_exec[0] = funct7_5 & Opcode[5];
        end
    end

    // funct3[0] inverts the sense of the Zero test within each comparison class.
    always_comb begin
        alu_br   = AluAdd;
        br_taken = 1'b0;
        case (funct3[2:1])
            2'b00: begin alu_br = AluSub;  br_taken = Zero ^ funct3[0];  end
            2'b10: begin alu_br = AluSlt;  br_taken = Zero ~^ funct3[0]; end
            2'b11: begin alu_br = AluSltu; br_taken = Zero ~^ funct3[0]; end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        AdrSrc      = 1'b0;
        AluSrcA     = 2'b00;
        AluSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ImmSrc      = 3'b000;
        Alu_Control = AluAdd;
        unique case (state_q)
            StFetch: begin
                MemRead   = 1'b1;
                AluSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_done) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                AluSrcA     = 2'b01;
                AluSrcB     = 2'b01;
                ImmSrc      = 3'b010;
                state_d     = dec_state;
                retire      = !dec_legal && !TRAP_ON_ILLEGAL;
                set_illegal = !dec_legal && TRAP_ON_ILLEGAL;
            end
            StMemAdr: begin
                AluSrcA = 2'b10;
                AluSrcB = 2'b01;
                ImmSrc  = Opcode[5] ? 3'b001 : 3'b000;
                state_d = Opcode[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                MemRead = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_done) state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = StFetch;
                retire    = 1'b1;
            end
            StMemWrite: begin
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_done) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StExecR, StExecI: begin
                AluSrcA     = 2'b10;
                AluSrcB     = (state_q == StExecI) ? 2'b01 : 2'b00;
                Alu_Control = alu_exec;
                state_d     = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                state_d  = StFetch;
                retire   = 1'b1;
            end
            StBranch: begin
                AluSrcA     = 2'b10;
                Alu_Control = alu_br;
                PCWrite     = br_taken;
                state_d     = StFetch;
                retire      = 1'b1;
            end
            StJal: begin
                PCWrite = 1'b1;
                AluSrcA = 2'b01;
                AluSrcB = 2'b10;
                state_d = StAluWb;
            end
            StJalrAdr: begin
                AluSrcA = 2'b10;
                AluSrcB = 2'b01;
                state_d = StJal;
            end
            StUpper: begin
                ImmSrc  = 3'b100;
                AluSrcB = 2'b01;
                AluSrcA = Opcode[5] ? 2'b11 : 2'b01;
                state_d = StAluWb;
            end
            StTrap: ;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            instret <= '0;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) instret <= instret + CNT_W'(1);
            if (set_illegal) illegal <= 1'b1;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: two controller configurations, each driven in turn against an
// instruction-level model that expands every opcode into its list of post-decode states.
module tb_multicycle_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [6:0] Opcode;
    logic [2:0] funct3;
    logic       funct7_5, Zero, mem_ready;

    logic        a_pcw, a_irw, a_rw, a_mw, a_mr, a_adr, a_ill;
    logic [1:0]  a_sa, a_sb, a_rs;
    logic [2:0]  a_imm;
    logic [3:0]  a_alu, a_state;
    logic [31:0] a_instret;
    logic        b_pcw, b_irw, b_rw, b_mw, b_mr, b_adr, b_ill;
    logic [1:0]  b_sa, b_sb, b_rs;
    logic [2:0]  b_imm;
    logic [3:0]  b_alu, b_state;
    logic [3:0]  b_instret;

    multicycle_controller #(.MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst_a), .Opcode(Opcode), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(a_pcw), .IRWrite(a_irw),
        .RegWrite(a_rw), .MemWrite(a_mw), .MemRead(a_mr), .AdrSrc(a_adr), .AluSrcA(a_sa),
        .AluSrcB(a_sb), .ResultSrc(a_rs), .ImmSrc(a_imm), .Alu_Control(a_alu),
        .state(a_state), .illegal(a_ill), .instret(a_instret)
    );

    multicycle_controller #(.MEM_HANDSHAKE(1'b0), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .Opcode(Opcode), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(b_pcw), .IRWrite(b_irw),
        .RegWrite(b_rw), .MemWrite(b_mw), .MemRead(b_mr), .AdrSrc(b_adr), .AluSrcA(b_sa),
        .AluSrcB(b_sb), .ResultSrc(b_rs), .ImmSrc(b_imm), .Alu_Control(b_alu),
        .state(b_state), .illegal(b_ill), .instret(b_instret)
    );

    // Control bundle bit map: 18 PCWrite, 17 IRWrite, 16 RegWrite, 15 MemWrite, 14 MemRead,
    // 13 AdrSrc, 12:11 AluSrcA, 10:9 AluSrcB, 8:7 ResultSrc, 6:4 ImmSrc, 3:0 Alu_Control.
    bit          sel_b = 1'b0;
    logic [18:0] act_ctrl;
    logic [3:0]  act_state;
    logic        act_ill;
    logic [31:0] act_instret;
    always_comb begin
        if (sel_b) begin
            act_ctrl = {b_pcw, b_irw, b_rw, b_mw, b_mr, b_adr, b_sa, b_sb, b_rs, b_imm, b_alu};
            act_state = b_state;
            act_ill = b_ill;
            act_instret = {28'd0, b_instret};
        end else begin
            act_ctrl = {a_pcw, a_irw, a_rw, a_mw, a_mr, a_adr, a_sa, a_sb, a_rs, a_imm, a_alu};
            act_state = a_state;
            act_ill = a_ill;
            act_instret = a_instret;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    // Model state
    bit          m_mh, m_mt;
    logic [31:0] m_mask;
    int          m_state;
    int          m_plan[$];
    logic [31:0] m_instret;
    bit          m_illegal;

    // Driver controls
    bit          rand_io = 1'b0;
    int          stall_state = -1;
    int          stall_left = 0;
    logic [6:0]  nxt_op;
    logic [2:0]  nxt_f3;
    logic        nxt_f7;
    int          tr_state[$];
    logic [18:0] tr_ctrl[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] exp_ctrl();
        logic pcw, irw, rw, mw, mr, adr, taken, done;
        logic [1:0] sa, sb, rs;
        logic [2:0] imm;
        logic [3:0] alu;
        pcw = 0; irw = 0; rw = 0; mw = 0; mr = 0; adr = 0; taken = 0;
        sa = 0; sb = 0; rs = 0; imm = 0; alu = 0;
        done = mem_ready || !m_mh;
        case (m_state)
            0: begin mr = 1; sb = 2'b10; rs = 2'b10; pcw = done; irw = done; end
            1: begin sa = 2'b01; sb = 2'b01; imm = 3'b010; end
            2: begin sa = 2'b10; sb = 2'b01; imm = Opcode[5] ? 3'b001 : 3'b000; end
            3: begin mr = 1; adr = 1; end
            4: begin rs = 2'b01; rw = 1; end
            5: begin mw = 1; adr = 1; end
            6, 7: begin
                sa = 2'b10;
                sb = (m_state == 7) ? 2'b01 : 2'b00;
                if (funct3 == 3'b101) alu = {funct3, funct7_5};
                else if (funct3 == 3'b000) alu = {funct3, funct7_5 && Opcode[5]};
                else alu = {funct3, 1'b0};
            end
            8: rw = 1;
            9: begin
                sa = 2'b10;
                case (funct3)
                    3'b000: begin alu = 4'b0001; taken = Zero;  end
                    3'b001: begin alu = 4'b0001; taken = !Zero; end
                    3'b100: begin alu = 4'b0100; taken = !Zero; end
                    3'b101: begin alu = 4'b0100; taken = Zero;  end
                    3'b110: begin alu = 4'b0110; taken = !Zero; end
                    3'b111: begin alu = 4'b0110; taken = Zero;  end
                    default: begin alu = 4'b0000; taken = 0; end
                endcase
                pcw = taken;
            end
            10: begin pcw = 1; sa = 2'b01; sb = 2'b10; end
            11: begin sa = 2'b10; sb = 2'b01; end
            12: begin imm = 3'b100; sb = 2'b01; sa = Opcode[5] ? 2'b11 : 2'b01; end
            default: ;
        endcase
        return {pcw, irw, rw, mw, mr, adr, sa, sb, rs, imm, alu};
    endfunction

    // Post-decode state sequence of each instruction class; empty means straight back to fetch.
    task automatic build_plan(input logic [6:0] op);
        m_plan.delete();
        case (op)
            7'b0000011: m_plan = '{2, 3, 4};
            7'b0100011: m_plan = '{2, 5};
            7'b0110011: m_plan = '{6, 8};
            7'b0010011: m_plan = '{7, 8};
            7'b1100011: m_plan = '{9};
            7'b1101111: m_plan = '{10, 8};
            7'b1100111: m_plan = '{11, 10, 8};
            7'b0110111, 7'b0010111: m_plan = '{12, 8};
            default: if (m_mt) m_plan = '{13};
        endcase
    endtask

    task automatic model_reset();
        m_state = 0;
        m_plan.delete();
        m_instret = 0;
        m_illegal = 0;
    endtask

    task automatic advance();
        int prev;
        bit done;
        if (sel_b ? rst_b : rst_a) begin
            model_reset();
            return;
        end
        prev = m_state;
        done = mem_ready || !m_mh;
        if (m_state == 13) begin
        end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !done) begin
        end else if (m_state == 0) begin
            m_state = 1;
        end else begin
            if (m_state == 1) build_plan(Opcode);
            if (m_plan.size() == 0) m_state = 0;
            else m_state = m_plan.pop_front();
        end
        if (m_state == 0 && prev != 0) m_instret = m_instret + 1;
        if (m_state == 13) m_illegal = 1;
    endtask

    task automatic pick_random(input bit allow_illegal);
        int k;
        k = $urandom_range(0, allow_illegal ? 10 : 8);
        case (k)
            0: nxt_op = 7'b0000011;
            1: nxt_op = 7'b0100011;
            2: nxt_op = 7'b0110011;
            3: nxt_op = 7'b0010011;
            4: nxt_op = 7'b1100011;
            5: nxt_op = 7'b1101111;
            6: nxt_op = 7'b1100111;
            7: nxt_op = 7'b0110111;
            8: nxt_op = 7'b0010111;
            9: nxt_op = 7'b1111111;
            default: nxt_op = 7'b0001011;
        endcase
        nxt_f3 = 3'($urandom_range(0, 7));
        nxt_f7 = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_next();
        if (rand_io) begin
            mem_ready = ($urandom_range(0, 3) != 0);
            Zero = 1'($urandom_range(0, 1));
            pick_random(sel_b);
            if (sel_b) rst_b = ($urandom_range(0, 63) == 0);
            else rst_a = ($urandom_range(0, 63) == 0);
        end else if (m_state == stall_state && stall_left > 0) begin
            mem_ready = 1'b0;
            stall_left--;
        end else begin
            mem_ready = 1'b1;
        end
        if (m_state == 1) begin
            Opcode = nxt_op;
            funct3 = nxt_f3;
            funct7_5 = nxt_f7;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cmp("state", 32'(act_state), 32'(m_state));
        cmp("ctrl", 32'(act_ctrl), 32'(exp_ctrl()));
        cmp("illegal", 32'(act_ill), 32'(m_illegal));
        cmp("instret", act_instret, m_instret & m_mask);
        tr_state.push_back(int'(act_state));
        tr_ctrl.push_back(act_ctrl);
        @(posedge clk);
        advance();
        #1;
        drive_next();
    endtask

    // Runs one instruction from FETCH back to FETCH; leaves its per-cycle trace behind.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        int guard;
        nxt_op = op;
        nxt_f3 = f3;
        nxt_f7 = f7;
        tr_state.delete();
        tr_ctrl.delete();
        guard = 0;
        do begin
            cycle();
            guard++;
        end while (m_state != 0 && guard < 40);
        if (guard >= 40) cmp("instr_timeout", 32'(guard), 32'd0);
    endtask

    int          n_rw;
    logic [31:0] saved;

    initial begin
        rst_a = 1; rst_b = 1;
        Opcode = 7'b0110011; funct3 = 0; funct7_5 = 0; Zero = 0; mem_ready = 0;
        m_mh = 1; m_mt = 1; m_mask = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_a = 0;
        cmp("rst_instret", a_instret, 32'd0);
        cmp("rst_illegal", 32'(a_ill), 32'd0);

        // FETCH holds while memory is not ready
        stall_state = 0; stall_left = 2;
        tr_state.delete(); tr_ctrl.delete();
        repeat (3) cycle();
        cmp("hold_state", 32'(tr_state[2]), 32'd0);
        cmp("hold_memread", 32'(tr_ctrl[0][14]), 32'd1);
        cmp("hold_irwrite", 32'(tr_ctrl[0][17] | tr_ctrl[1][17] | tr_ctrl[2][17]), 32'd0);

        run_instr(7'b0110011, 3'b000, 1'b1);
        cmp("sub_len", 32'(tr_state.size()), 32'd4);
        cmp("sub_exec_state", 32'(tr_state[2]), 32'd6);
        cmp("sub_alu", 32'(tr_ctrl[2][3:0]), 32'b0001);
        cmp("sub_wb_regwrite", 32'(tr_ctrl[3][16]), 32'd1);
        cmp("sub_instret", a_instret, 32'd1);

        run_instr(7'b0010011, 3'b000, 1'b1);
        cmp("addi_alu", 32'(tr_ctrl[2][3:0]), 32'b0000);
        run_instr(7'b0010011, 3'b101, 1'b1);
        cmp("srai_alu", 32'(tr_ctrl[2][3:0]), 32'b1011);

        Zero = 1;
        run_instr(7'b1100011, 3'b101, 1'b0);
        cmp("bge_len", 32'(tr_state.size()), 32'd3);
        cmp("bge_taken", 32'(tr_ctrl[2][18]), 32'd1);
        cmp("bge_alu", 32'(tr_ctrl[2][3:0]), 32'b0100);
        Zero = 0;
        run_instr(7'b1100011, 3'b101, 1'b0);
        cmp("bge_not_taken", 32'(tr_ctrl[2][18]), 32'd0);
        cmp("bge_nt_len", 32'(tr_state.size()), 32'd3);

        stall_state = 3; stall_left = 2;
        run_instr(7'b0000011, 3'b010, 1'b0);
        cmp("lw_len", 32'(tr_state.size()), 32'd7);
        n_rw = 0;
        foreach (tr_ctrl[i]) begin
            if (tr_ctrl[i][16]) begin
                n_rw++;
                cmp("lw_resultsrc", 32'(tr_ctrl[i][8:7]), 32'b01);
            end
        end
        cmp("lw_regwrite_pulses", 32'(n_rw), 32'd1);

        // Illegal opcode traps and freezes the counter until reset
        saved = a_instret;
        nxt_op = 7'b1111111;
        for (int i = 0; i < 6; i++) cycle();
        cmp("trap_state", 32'(a_state), 32'd13);
        cmp("trap_illegal", 32'(a_ill), 32'd1);
        cmp("trap_instret", a_instret, saved);
        rst_a = 1;
        cycle();
        rst_a = 0;
        cmp("trap_rst_state", 32'(a_state), 32'd0);
        cmp("trap_rst_illegal", 32'(a_ill), 32'd0);

        rand_io = 1;
        for (int i = 0; i < 3000; i++) cycle();
        rand_io = 0;
        rst_a = 1;
        cycle();

        // Second configuration: no handshake, illegal opcodes retire, 4-bit counter
        sel_b = 1;
        m_mh = 0; m_mt = 0; m_mask = 32'h0000_000F;
        model_reset();
        rst_b = 1;
        cycle();
        rst_b = 0;
        stall_state = -1;
        run_instr(7'b1111111, 3'b000, 1'b0);
        cmp("nop_len", 32'(tr_state.size()), 32'd2);
        cmp("nop_instret", 32'(b_instret), 32'd1);
        stall_state = 0; stall_left = 100;
        mem_ready = 0;
        run_instr(7'b0110011, 3'b000, 1'b0);
        cmp("nohs_len", 32'(tr_state.size()), 32'd4);
        stall_state = -1;
        for (int i = 0; i < 13; i++) run_instr(7'b0010011, 3'b000, 1'b0);
        cmp("cnt_15", 32'(b_instret), 32'd15);
        run_instr(7'b0110111, 3'b000, 1'b0);
        cmp("cnt_wrap", 32'(b_instret), 32'd0);

        rand_io = 1;
        for (int i = 0; i < 3000; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
